// File: rtl/irq_controller.sv
// irq_controller
//   Receives the one-cycle interrupt pulse and ID from the switch I/O block.
//   It keeps one pending bit per ID and masks it with an enable register. The
//   lowest nonzero eligible ID is presented to the core over an irq_req/irq_ack
//   handshake. The acknowledged ID stays in service until software writes EOI.
//
// Ports
//   clk, reset_n           : clock (rising edge), synchronous active-low reset
//   interrupt, interrupt_id: event pulse and source ID (ID 0 is dropped)
//   wEn, addr, dataIn      : data-memory bus write side
//   dataOut                : combinational bus read data, 0 outside the window
//   irq_req, irq_id        : request to the core and the requested ID
//   irq_ack                : core accepted the trap (only looked at while requesting)
//
// Register window at BASE_ADDR
//   0x0 PENDING (R/W1C), 0x4 ENABLE (R/W, bit 0 forced 0),
//   0x8 IN_SERVICE (RO), 0xC EOI (WO)
//   0x10 OVERFLOW (R/W1C, sticky) exists only when IRQ_OVERFLOW_EN is defined.
//   Without that macro, offset 0x10 reads 0.

module irq_controller #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
    parameter int          ID_W      = 5
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            interrupt,
    input  logic [ID_W-1:0] interrupt_id,
    input  logic            wEn,
    input  logic [31:0]     addr,
    input  logic [31:0]     dataIn,
    output logic [31:0]     dataOut,
    output logic            irq_req,
    output logic [ID_W-1:0] irq_id,
    input  logic            irq_ack
);

    localparam int NSRC = 1 << ID_W;

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t          state, state_nxt;
    logic [NSRC-1:0] pending, pending_nxt;
    logic [NSRC-1:0] enable, enable_nxt;
    logic [NSRC-1:0] eligible, w1c, pulse_vec, ack_clr;
    logic [ID_W-1:0] in_service, in_service_nxt;
    logic [ID_W-1:0] irq_id_nxt, winner;
    logic            irq_req_nxt;

    logic sel_pend, sel_en, sel_is, sel_eoi, sel_ovf;

    assign sel_pend = (addr == BASE_ADDR);
    assign sel_en   = (addr == BASE_ADDR + 32'h4);
    assign sel_is   = (addr == BASE_ADDR + 32'h8);
    assign sel_eoi  = (addr == BASE_ADDR + 32'hC);
    assign sel_ovf  = (addr == BASE_ADDR + 32'h10);

    // ID 0 means "no source", so it never produces a set.
    assign pulse_vec = (interrupt && interrupt_id != '0) ? (NSRC'(1) << interrupt_id) : '0;
    assign w1c       = (wEn && sel_pend) ? dataIn[NSRC-1:0] : '0;
    assign eligible  = pending & enable;

    // Lowest nonzero index wins, so scan downward and let the last hit stand.
    always_comb begin
        winner = '0;
        for (int i = NSRC - 1; i >= 1; i--) begin
            if (eligible[i]) winner = ID_W'(i);
        end
    end

`ifdef IRQ_OVERFLOW_EN
    logic [NSRC-1:0] overflow, overflow_nxt;

    // A merged pulse counts as overflow unless that same bit is being cleared
    // this cycle. In that case the pulse simply re-pends the bit.
    always_comb begin
        overflow_nxt = overflow;
        if (wEn && sel_ovf) overflow_nxt = overflow_nxt & ~dataIn[NSRC-1:0];
        overflow_nxt = overflow_nxt | (pulse_vec & pending & ~w1c);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) overflow <= '0;
        else          overflow <= overflow_nxt;
    end
`endif

    // Next-state / output logic
    always_comb begin
        state_nxt      = state;
        irq_req_nxt    = irq_req;
        irq_id_nxt     = irq_id;
        in_service_nxt = in_service;
        ack_clr        = '0;
        case (state)
            IDLE: begin
                if (eligible != '0) begin
                    irq_req_nxt = 1'b1;
                    irq_id_nxt  = winner;
                    state_nxt   = REQ;
                end
            end
            REQ: begin
                // irq_id is frozen here: a lower ID arriving later waits its turn.
                // Acknowledgement takes priority over withdrawal.
                if (irq_ack) begin
                    ack_clr        = NSRC'(1) << irq_id;
                    in_service_nxt = irq_id;
                    irq_req_nxt    = 1'b0;
                    state_nxt      = SERVICE;
                end else if (!pending[irq_id] || !enable[irq_id]) begin
                    irq_req_nxt = 1'b0;
                    state_nxt   = IDLE;
                end
            end
            SERVICE: begin
                if (wEn && sel_eoi) begin
                    in_service_nxt = '0;
                    state_nxt      = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A new pulse beats both a W1C and an ack clear of the same bit.
        pending_nxt = ((pending & ~w1c & ~ack_clr) | pulse_vec) & ~NSRC'(1);
        enable_nxt  = (wEn && sel_en) ? (dataIn[NSRC-1:0] & ~NSRC'(1)) : enable;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            pending    <= '0;
            enable     <= '0;
            in_service <= '0;
            irq_req    <= 1'b0;
            irq_id     <= '0;
        end else begin
            state      <= state_nxt;
            pending    <= pending_nxt;
            enable     <= enable_nxt;
            in_service <= in_service_nxt;
            irq_req    <= irq_req_nxt;
            irq_id     <= irq_id_nxt;
        end
    end

    // Bus read
    always_comb begin
        dataOut = '0;
        if (sel_pend)    dataOut = 32'(pending);
        else if (sel_en) dataOut = 32'(enable);
        else if (sel_is) dataOut = 32'(in_service);
`ifdef IRQ_OVERFLOW_EN
        else if (sel_ovf) dataOut = 32'(overflow);
`endif
    end

endmodule

// File: tb/tb_irq_controller.sv
module tb_irq_controller;

    localparam logic [31:0] BASE = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        interrupt = 1'b0;
    logic [4:0]  interrupt_id = '0;
    logic        wEn = 1'b0;
    logic [31:0] addr = BASE;
    logic [31:0] dataIn = '0;
    logic [31:0] dataOut;
    logic        irq_req;
    logic [4:0]  irq_id;
    logic        irq_ack = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    irq_controller #(.BASE_ADDR(BASE), .ID_W(5)) dut (
        .clk(clk), .reset_n(reset_n), .interrupt(interrupt), .interrupt_id(interrupt_id),
        .wEn(wEn), .addr(addr), .dataIn(dataIn), .dataOut(dataOut),
        .irq_req(irq_req), .irq_id(irq_id), .irq_ack(irq_ack)
    );

    always #5 clk = ~clk;

    // Reference model
    // Phases: 0 = nothing presented, 1 = requesting, 2 = in service.
    logic [31:0] mp, me, mo;
    int          mis, mid, mphase;
    bit          mreq;

    function automatic int lowest(input logic [31:0] v);
        for (int i = 1; i < 32; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic logic [31:0] mread(input logic [31:0] a);
        if (a == BASE)         return mp;
        if (a == BASE + 4)     return me;
        if (a == BASE + 8)     return (mphase == 2) ? 32'(mis) : 32'h0;
`ifdef IRQ_OVERFLOW_EN
        if (a == BASE + 32'h10) return mo;
`endif
        return 32'h0;
    endfunction

    task automatic model_step();
        logic [31:0] clr, np, no;
        int k;
        if (!reset_n) begin
            mp = 0; me = 0; mo = 0; mis = 0; mid = 0; mphase = 0; mreq = 0;
            return;
        end
        clr = (wEn && addr == BASE) ? dataIn : 32'h0;
        np  = mp & ~clr;
        no  = mo;
        if (wEn && addr == BASE + 32'h10) no = no & ~dataIn;
        case (mphase)
            0: if ((mp & me) != 0) begin mreq = 1; mid = lowest(mp & me); mphase = 1; end
            1: if (irq_ack) begin
                   np[mid] = 1'b0; mis = mid; mreq = 0; mphase = 2;
               end else if (!mp[mid] || !me[mid]) begin
                   mreq = 0; mphase = 0;
               end
            default: if (wEn && addr == BASE + 32'hC) begin mis = 0; mphase = 0; end
        endcase
        if (interrupt && interrupt_id != 0) begin
            k = int'(interrupt_id);
            np[k] = 1'b1;
            if (mp[k] && !clr[k]) no[k] = 1'b1;
        end
        if (wEn && addr == BASE + 4) me = dataIn & 32'hFFFF_FFFE;
        mp = np;
        mo = no;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // The model advances with the inputs held across the edge. The outputs
    // are compared 1 ns after the edge, and single-cycle inputs then drop.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("irq_req", 32'(irq_req), 32'(mreq));
        if (mreq) chk("irq_id", 32'(irq_id), 32'(mid));
        interrupt = 0; wEn = 0; irq_ack = 0; reset_n = 1;
    endtask

    task automatic rd(input string tag, input logic [31:0] off, input logic [31:0] exp);
        addr = BASE + off;
        #1;
        chk(tag, dataOut, exp);
        chk("model_rd", dataOut, mread(addr));
    endtask

    task automatic pulse(input int id);
        interrupt = 1; interrupt_id = 5'(id);
        tick();
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d);
        wEn = 1; addr = BASE + off; dataIn = d;
        tick();
    endtask

    task automatic do_reset();
        reset_n = 0;
        tick();
    endtask

    initial begin
        logic [31:0] offs [6];
        offs = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};

        // Reset state
        do_reset();
        for (int i = 0; i < 5; i++) rd("reset_rd", offs[i], 32'h0);

        // Capture with ENABLE=0, then enable
        pulse(3);
        rd("pend_id3", 0, 32'h8);
        chk("no_req_disabled", 32'(irq_req), 32'h0);
        wr(4, 32'h8);
        chk("req_lat1", 32'(irq_req), 32'h0);
        tick();
        chk("req_lat2", 32'(irq_req), 32'h1);
        chk("req_id3", 32'(irq_id), 32'd3);

        // No preemption; lower ID is served after EOI
        do_reset();
        wr(4, 32'hFFFF_FFFE);
        pulse(5);
        pulse(2);
        tick();
        chk("frozen_id5", 32'(irq_id), 32'd5);
        irq_ack = 1; tick();
        rd("is_5", 8, 32'd5);
        wr(32'hC, 32'h0);
        tick();
        chk("next_req", 32'(irq_req), 32'h1);
        chk("next_id2", 32'(irq_id), 32'd2);

        // Ack and W1C together: ack wins
        do_reset();
        wr(4, 32'hFFFF_FFFE);
        pulse(4);
        tick();
        irq_ack = 1; wEn = 1; addr = BASE; dataIn = 32'h10;
        tick();
        rd("ack_wins_is", 8, 32'd4);
        rd("ack_wins_pend", 0, 32'h0);

        // Re-pend during service, ack ignored in service
        do_reset();
        wr(4, 32'hFFFF_FFFE);
        pulse(6);
        tick();
        irq_ack = 1; tick();
        pulse(6);
        rd("repend", 0, 32'h40);
        irq_ack = 1; tick();
        chk("svc_ack_ignored", 32'(irq_req), 32'h0);
        rd("svc_is6", 8, 32'd6);
        wr(32'hC, 32'h0);
        rd("eoi_is0", 8, 32'h0);
        tick();
        chk("rereq", 32'(irq_req), 32'h1);
        chk("rereq_id6", 32'(irq_id), 32'd6);

        // Reset mid-request
        do_reset();
        chk("rst_req", 32'(irq_req), 32'h0);
        for (int i = 0; i < 5; i++) rd("rst_mid_rd", offs[i], 32'h0);

        // Overflow register
        do_reset();
        pulse(7);
        pulse(7);
`ifdef IRQ_OVERFLOW_EN
        rd("ovf_set", 32'h10, 32'h80);
`else
        rd("ovf_absent", 32'h10, 32'h0);
`endif
        wr(32'h10, 32'h80);
        rd("ovf_clr", 32'h10, 32'h0);

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            reset_n      = ($urandom_range(0, 299) != 0);
            interrupt    = ($urandom_range(0, 2) == 0);
            interrupt_id = 5'($urandom_range(0, 31));
            irq_ack      = ($urandom_range(0, 2) == 0);
            wEn          = ($urandom_range(0, 5) == 0);
            addr         = BASE + offs[$urandom_range(0, 5)];
            dataIn       = ($urandom_range(0, 1) == 0) ? $urandom : (32'h1 << $urandom_range(0, 31));
            #1;
            chk("rand_rd", dataOut, mread(addr));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
